// File: rtl/sync_fifo_param_if.sv
// Producer/consumer side of sync_fifo_param: write/read requests, data, occupancy and error flags.
// master drives requests and write data; slave is the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] buf_in;
  logic                  wr_en;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  rd_valid;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CW-1:0]         fifo_counter;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output buf_in, wr_en, rd_en, clr_err,
    input  buf_out, rd_valid, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );

  modport slave (
    input  buf_in, wr_en, rd_en, clr_err,
    output buf_out, rd_valid, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO; read latency 1 cycle (standard) or 0 (FWFT, word shown the cycle after it is written).
// Backpressure via buf_full/buf_empty; rejected writes/reads leave state untouched and set sticky overflow/underflow.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end
  if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  rd_acc, wr_acc;
  logic                  empty_q, full_q, ae_q, af_q, ovf_q, udf_q;

  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign rd_acc = bus.rd_en & ~empty_q;
  assign wr_acc = bus.wr_en & (~full_q | rd_acc);

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == FULL_LVL);
      ae_q    <= (count_nxt <= AE_LVL);
      af_q    <= (count_nxt >= AF_LVL);
      // New errors take priority over a same-cycle clear.
      ovf_q   <= (ovf_q & ~bus.clr_err) | (bus.wr_en & ~wr_acc);
      udf_q   <= (udf_q & ~bus.clr_err) | (bus.rd_en & ~rd_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.buf_in;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  vld_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign bus.buf_out  = dout_q;
    assign bus.rd_valid = vld_q;
  end else begin : g_fwft
    // Head word is shown directly; forced to zero while empty so reset reads back 0.
    assign bus.buf_out  = empty_q ? '0 : mem[rd_ptr];
    assign bus.rd_valid = ~empty_q;
  end

  assign bus.buf_empty    = empty_q;
  assign bus.buf_full     = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.fifo_counter = count;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: DEPTH=8, AE=2, AF=6, one standard-mode and one FWFT instance.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(8)) bs ();
  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(8)) bf ();

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .bus(bs)
  );
  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .bus(bf)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bs.buf_in = 8'h11; bs.wr_en = 1'b1; step;
    bs.buf_in = 8'h22; bs.rd_en = 1'b1; step;
    total++; if (bs.buf_out !== 8'h11) begin bad++; $display("FAIL pre_rst_dout: got %h want 11", bs.buf_out); end
    total++; if (bs.fifo_counter !== 4'd1) begin bad++; $display("FAIL pre_rst_cnt: got %0d want 1", bs.fifo_counter); end
    // asynchronous reset in the middle of traffic
    rst = 1'b0; #1;
    total++; if (bs.fifo_counter !== 4'd0) begin bad++; $display("FAIL rst_async_cnt: got %0d want 0", bs.fifo_counter); end
    total++; if (bs.buf_out !== 8'h00) begin bad++; $display("FAIL rst_async_dout: got %h want 00", bs.buf_out); end
    total++; if (bs.buf_empty !== 1'b1) begin bad++; $display("FAIL rst_async_empty: got %b want 1", bs.buf_empty); end
    step; step;
    bs.wr_en = 1'b0; bs.rd_en = 1'b0; rst = 1'b1;
    step;
    total++; if (bs.fifo_counter !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", bs.fifo_counter); end
    total++; if (bs.buf_empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", bs.buf_empty); end
    total++; if (bs.almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae: got %b want 1", bs.almost_empty); end
    total++; if (bs.almost_full !== 1'b0) begin bad++; $display("FAIL rst_af: got %b want 0", bs.almost_full); end
    total++; if (bs.buf_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", bs.buf_full); end
    total++; if (bs.overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", bs.overflow); end
    total++; if (bs.underflow !== 1'b0) begin bad++; $display("FAIL rst_udf: got %b want 0", bs.underflow); end
    total++; if (bs.buf_out !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", bs.buf_out); end
    total++; if (bs.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rdv: got %b want 0", bs.rd_valid); end
    total++; if (bf.buf_empty !== 1'b1) begin bad++; $display("FAIL rst_fwft_empty: got %b want 1", bf.buf_empty); end
  endtask

  task automatic test_fill_drain;
    logic e;
    int   npulse;
    for (int i = 1; i <= 8; i++) begin
      bs.buf_in = 8'(i); bs.wr_en = 1'b1; step;
      total++; if (bs.fifo_counter !== 4'(i)) begin bad++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, bs.fifo_counter, i); end
      e = (i >= 6);
      total++; if (bs.almost_full !== e) begin bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, bs.almost_full, e); end
      e = (i <= 2);
      total++; if (bs.almost_empty !== e) begin bad++; $display("FAIL fill_ae[%0d]: got %b want %b", i, bs.almost_empty, e); end
      e = (i == 8);
      total++; if (bs.buf_full !== e) begin bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, bs.buf_full, e); end
    end
    bs.wr_en = 1'b0;
    npulse = 0;
    for (int i = 1; i <= 8; i++) begin
      bs.rd_en = 1'b1; step;
      if (bs.rd_valid === 1'b1) npulse++;
      total++; if (bs.buf_out !== 8'(i)) begin bad++; $display("FAIL drain_dat[%0d]: got %h want %h", i, bs.buf_out, 8'(i)); end
      total++; if (bs.fifo_counter !== 4'(8 - i)) begin bad++; $display("FAIL drain_cnt[%0d]: got %0d want %0d", i, bs.fifo_counter, 8 - i); end
    end
    bs.rd_en = 1'b0; step;
    if (bs.rd_valid === 1'b1) npulse++;
    total++; if (npulse != 8) begin bad++; $display("FAIL drain_pulses: got %0d want 8", npulse); end
    total++; if (bs.buf_empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", bs.buf_empty); end
    total++; if (bs.buf_out !== 8'h08) begin bad++; $display("FAIL drain_hold: got %h want 08", bs.buf_out); end
  endtask

  task automatic test_errors;
    for (int i = 1; i <= 8; i++) begin
      bs.buf_in = 8'(8'h30 + i); bs.wr_en = 1'b1; step;
    end
    bs.buf_in = 8'h99; step;
    total++; if (bs.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bs.overflow); end
    total++; if (bs.fifo_counter !== 4'd8) begin bad++; $display("FAIL ovf_cnt: got %0d want 8", bs.fifo_counter); end
    bs.wr_en = 1'b0; step;
    total++; if (bs.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bs.overflow); end
    for (int i = 1; i <= 8; i++) begin
      bs.rd_en = 1'b1; step;
      total++; if (bs.buf_out !== 8'(8'h30 + i)) begin bad++; $display("FAIL ovf_dat[%0d]: got %h want %h", i, bs.buf_out, 8'(8'h30 + i)); end
    end
    step;
    total++; if (bs.underflow !== 1'b1) begin bad++; $display("FAIL udf_set: got %b want 1", bs.underflow); end
    total++; if (bs.fifo_counter !== 4'd0) begin bad++; $display("FAIL udf_cnt: got %0d want 0", bs.fifo_counter); end
    total++; if (bs.rd_valid !== 1'b0) begin bad++; $display("FAIL udf_rdv: got %b want 0", bs.rd_valid); end
    bs.rd_en = 1'b0; bs.clr_err = 1'b1; step;
    total++; if (bs.overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf: got %b want 0", bs.overflow); end
    total++; if (bs.underflow !== 1'b0) begin bad++; $display("FAIL clr_udf: got %b want 0", bs.underflow); end
    bs.rd_en = 1'b1; step;
    total++; if (bs.underflow !== 1'b1) begin bad++; $display("FAIL clr_vs_set: got %b want 1", bs.underflow); end
    bs.rd_en = 1'b0; step;
    total++; if (bs.underflow !== 1'b0) begin bad++; $display("FAIL clr_again: got %b want 0", bs.underflow); end
    bs.clr_err = 1'b0;
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp;
    for (int i = 1; i <= 8; i++) begin
      bs.buf_in = 8'(8'h40 + i); bs.wr_en = 1'b1; step;
    end
    bs.buf_in = 8'hAA; bs.rd_en = 1'b1; step;
    total++; if (bs.fifo_counter !== 4'd8) begin bad++; $display("FAIL simf_cnt: got %0d want 8", bs.fifo_counter); end
    total++; if (bs.buf_out !== 8'h41) begin bad++; $display("FAIL simf_dat: got %h want 41", bs.buf_out); end
    total++; if (bs.overflow !== 1'b0) begin bad++; $display("FAIL simf_ovf: got %b want 0", bs.overflow); end
    bs.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 8'(8'h42 + i) : 8'hAA;
      step;
      total++; if (bs.buf_out !== exp) begin bad++; $display("FAIL simf_drain[%0d]: got %h want %h", i, bs.buf_out, exp); end
    end
    bs.buf_in = 8'h55; bs.wr_en = 1'b1; step;
    total++; if (bs.fifo_counter !== 4'd1) begin bad++; $display("FAIL sime_cnt: got %0d want 1", bs.fifo_counter); end
    total++; if (bs.underflow !== 1'b1) begin bad++; $display("FAIL sime_udf: got %b want 1", bs.underflow); end
    total++; if (bs.rd_valid !== 1'b0) begin bad++; $display("FAIL sime_rdv: got %b want 0", bs.rd_valid); end
    bs.wr_en = 1'b0; bs.clr_err = 1'b1; step;
    total++; if (bs.buf_out !== 8'h55) begin bad++; $display("FAIL sime_dat: got %h want 55", bs.buf_out); end
    total++; if (bs.underflow !== 1'b0) begin bad++; $display("FAIL sime_clr: got %b want 0", bs.underflow); end
    bs.rd_en = 1'b0; bs.clr_err = 1'b0;
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] exp;
    int         ph;
    d = 8'h60;
    for (int i = 0; i < 4; i++) begin
      bs.buf_in = d; bs.wr_en = 1'b1; q.push_back(d); d = d + 8'd1; step;
    end
    for (int c = 0; c < 20; c++) begin
      ph = c % 4;
      bs.wr_en = (ph == 0) || (ph == 3);
      bs.rd_en = (ph == 1) || (ph == 2);
      bs.buf_in = d;
      if (bs.wr_en) begin q.push_back(d); d = d + 8'd1; end
      step;
      if (bs.rd_en) begin
        exp = q.pop_front();
        total++; if (bs.buf_out !== exp) begin bad++; $display("FAIL wrap_dat[%0d]: got %h want %h", c, bs.buf_out, exp); end
      end
      total++; if (bs.fifo_counter !== 4'(q.size())) begin bad++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", c, bs.fifo_counter, q.size()); end
      total++; if ((bs.buf_full !== 1'b0) || (bs.buf_empty !== 1'b0)) begin bad++; $display("FAIL wrap_flags[%0d]: got full=%b empty=%b want 0 0", c, bs.buf_full, bs.buf_empty); end
    end
    bs.wr_en = 1'b0; bs.rd_en = 1'b1;
    while (q.size() > 0) begin
      exp = q.pop_front();
      step;
      total++; if (bs.buf_out !== exp) begin bad++; $display("FAIL wrap_tail: got %h want %h", bs.buf_out, exp); end
    end
    bs.rd_en = 1'b0; step;
    total++; if (bs.buf_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", bs.buf_empty); end
  endtask

  task automatic test_fwft;
    bf.buf_in = 8'h5A; bf.wr_en = 1'b1; step;
    bf.wr_en = 1'b0;
    total++; if (bf.buf_out !== 8'h5A) begin bad++; $display("FAIL fwft_show: got %h want 5a", bf.buf_out); end
    total++; if (bf.buf_empty !== 1'b0) begin bad++; $display("FAIL fwft_empty: got %b want 0", bf.buf_empty); end
    total++; if (bf.rd_valid !== 1'b1) begin bad++; $display("FAIL fwft_rdv: got %b want 1", bf.rd_valid); end
    bf.buf_in = 8'h6B; bf.wr_en = 1'b1; step;
    bf.buf_in = 8'h7C; step;
    bf.wr_en = 1'b0;
    total++; if (bf.buf_out !== 8'h5A) begin bad++; $display("FAIL fwft_hold: got %h want 5a", bf.buf_out); end
    total++; if (bf.fifo_counter !== 4'd3) begin bad++; $display("FAIL fwft_cnt: got %0d want 3", bf.fifo_counter); end
    bf.rd_en = 1'b1; step;
    total++; if (bf.buf_out !== 8'h6B) begin bad++; $display("FAIL fwft_pop1: got %h want 6b", bf.buf_out); end
    step;
    total++; if (bf.buf_out !== 8'h7C) begin bad++; $display("FAIL fwft_pop2: got %h want 7c", bf.buf_out); end
    step;
    bf.rd_en = 1'b0;
    total++; if (bf.buf_empty !== 1'b1) begin bad++; $display("FAIL fwft_pop3_empty: got %b want 1", bf.buf_empty); end
    total++; if (bf.rd_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop3_rdv: got %b want 0", bf.rd_valid); end
    total++; if (bf.underflow !== 1'b0) begin bad++; $display("FAIL fwft_no_udf: got %b want 0", bf.underflow); end
    bf.buf_in = 8'h8D; bf.wr_en = 1'b1; bf.rd_en = 1'b1; step;
    bf.wr_en = 1'b0; bf.rd_en = 1'b0;
    total++; if (bf.underflow !== 1'b1) begin bad++; $display("FAIL fwft_sime_udf: got %b want 1", bf.underflow); end
    total++; if (bf.fifo_counter !== 4'd1) begin bad++; $display("FAIL fwft_sime_cnt: got %0d want 1", bf.fifo_counter); end
    total++; if (bf.buf_out !== 8'h8D) begin bad++; $display("FAIL fwft_sime_dat: got %h want 8d", bf.buf_out); end
  endtask

  initial begin
    rst = 1'b0;
    bs.buf_in = '0; bs.wr_en = 1'b0; bs.rd_en = 1'b0; bs.clr_err = 1'b0;
    bf.buf_in = '0; bf.wr_en = 1'b0; bf.rd_en = 1'b0; bf.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step;
    test_reset;
    test_fill_drain;
    test_errors;
    test_simultaneous;
    test_wrap;
    test_fwft;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO that succeeds the fixed Sync_FIFO. It keeps the buf_in / buf_out / wr_en / rd_en / buf_empty / buf_full / fifo_counter interface and adds configurable width and depth, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between single-clock producer and consumer blocks, and the existing layered fifo testbench drives it through an extended interface.

Parameters:
DATA_WIDTH, 8, width of buf_in and buf_out.
DEPTH, 16, number of entries; power of two, at least 4.
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  asynchronous reset, active-low (rst=0 resets).
buf_in  in  DATA_WIDTH  write data.
wr_en  in  1  write request.
rd_en  in  1  read request or pop.
clr_err  in  1  synchronous clear of overflow and underflow.
buf_out  out  DATA_WIDTH  read data.
rd_valid  out  1  standard mode: buf_out is updated this cycle. FWFT mode: equals !buf_empty.
buf_empty  out  1  count == 0.
buf_full  out  1  count == DEPTH.
almost_empty  out  1  count <= AE_THRESH.
almost_full  out  1  count >= AF_THRESH.
fifo_counter  out  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
overflow  out  1  sticky flag: a write was rejected.
underflow  out  1  sticky flag: a read was rejected.

Behaviour:
- Reset values while rst=0, applied asynchronously:
  - wr_ptr = rd_ptr = 0 and fifo_counter = 0.
  - buf_out = 0 and rd_valid = 0.
  - buf_empty = 1 and buf_full = 0.
  - almost_empty = 1 and almost_full = 0 (given legal thresholds).
  - overflow = underflow = 0.
  - Memory array is not reset.
- Reset asserted mid-operation discards all contents immediately. The first cycle after release behaves as an empty FIFO.
- Read acceptance: rd_acc = rd_en & !buf_empty.
- Write acceptance: wr_acc = wr_en & (!buf_full | rd_acc). When full, a simultaneous read frees the slot, so the write is accepted.
- Counter update per cycle:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - Both or neither: unchanged.
- Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
- All flags are registered and derived from the next count, so they change on the same edge as fifo_counter.
- Empty with wr_en=1 and rd_en=1: the write is accepted, the read is rejected and underflow sets. This holds in both modes.
- Standard mode (FWFT=0):
  - On rd_acc, buf_out takes mem[rd_ptr] at the next edge and rd_valid=1 for that one cycle. Read latency is 1 cycle.
  - buf_out holds its value otherwise.
  - Write-to-empty-deassert latency is 1 cycle.
- FWFT mode (FWFT=1):
  - buf_out = mem[rd_ptr] continuously whenever !buf_empty; rd_en acts as a pop.
  - A word written into an empty FIFO is on buf_out in the cycle after the write edge, together with buf_empty=0.
  - buf_out is don't-care while empty.
- overflow sets on (wr_en & !wr_acc). underflow sets on (rd_en & !rd_acc).
- clr_err=1 clears both sticky flags at the next edge. If a new error occurs in the same cycle, set wins.
- Rejected operations never change memory, pointers or the counter.
- Illegal parameters (DEPTH not a power of two, thresholds out of range) are caught by an elaboration-time $error.

Test Plan:
- Reset/flags: DEPTH=8, AE=2, AF=6. Hold rst=0 mid-traffic, then release → counter=0, empty=1, almost_empty=1, full=0, overflow=0, buf_out=0.
- Fill/drain, standard mode: write 0x01..0x08 → full=1 and almost_full from count 6. Read 8 times → 0x01..0x08 in order, each one cycle after its rd_en, rd_valid pulsed 8 times, empty=1 at the end.
- Overflow/underflow: write a 9th word into the full FIFO → overflow=1, counter stays 8. Read from empty → underflow=1. Pulse clr_err → both 0. Error and clr_err in the same cycle → flag stays 1.
- Simultaneous: on full, wr=rd=1 with 0xAA → counter stays 8 and 0xAA is read last after draining. On empty, wr=rd=1 → counter becomes 1 and underflow=1.
- Wrap-around: 20 cycles of interleaved write/read with counter between 3 and 5 → data in order across the pointer wrap, no spurious full or empty.
- FWFT=1: write 0x5A to empty → buf_out=0x5A and empty=0 the next cycle with no rd_en. Pop → empty=1, and the next word is shown immediately if the FIFO is non-empty.
